flexbex_irq_source_arbiter: RTL and testbench

- Platform-side interrupt source for the flexbex core. Drives the core's single interrupt request and 5-bit interrupt id, and consumes the core's acknowledge.
- Collects NUM_SRC interrupt lines, each either edge-latched or level. Masks them with a per-source enable and selects one by fixed priority, lowest index wins.
- Holds the request and id stable until the core acknowledges or the request is withdrawn. Sits between peripherals and the core's `irq_i`/`irq_id_i` inputs.

---
 rtl/flexbex_irq_source_arbiter.sv | 122 ++++++++++++
 tb/tb_flexbex_irq_source_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_irq_source_arbiter.sv
// flexbex_irq_source_arbiter
//   Platform-side interrupt source for the flexbex core. It collects NUM_SRC
//   interrupt lines, each either rising-edge latched or level. It masks them
//   with a per-source enable and picks one by fixed priority, where the lowest
//   index wins. It presents that one as irq_o/irq_id_o and holds it stable
//   until the core acknowledges it or the request is withdrawn.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   src_i          raw interrupt lines, synchronous to clk
//   src_en_i       per-source enable, 0 masks the source
//   irq_o          interrupt request to the core
//   irq_id_o       id of the presented source (holds its last value when idle)
//   irq_ack_i      single-cycle acknowledge from the core
//   irq_ack_id_i   id being acknowledged
//   pending_o      pending vector before masking
//   ack_err_o      one-cycle pulse, registered, flagging an illegal acknowledge
module flexbex_irq_source_arbiter #(
  parameter int unsigned NUM_SRC   = 32,
  parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               ack_err_o
);

  localparam logic [NUM_SRC-1:0] EdgeSrc = EDGE_MASK[NUM_SRC-1:0];

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] epend_q, epend_d;
  logic [4:0]         id_q, id_d;
  logic               ack_err_q, ack_err_d;

  logic [NUM_SRC-1:0] pending, eligible, id_sel;
  logic [4:0]         win_id;
  logic               win_vld, elig_cur, ack_hit;

  // Edge sources keep their own sticky bit; level sources are simply the
  // registered line, so an acknowledge cannot clear them.
  assign pending  = (epend_q & EdgeSrc) | (src_q & ~EdgeSrc);
  assign eligible = pending & src_en_i;

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_id  = 5'(i);
      end
    end
  end

  // One-hot of the presented id. Decoding through a compare keeps the
  // 5-bit id safe to use when NUM_SRC < 32.
  always_comb begin
    id_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) id_sel[i] = (id_q == 5'(i));
  end

  assign elig_cur = |(eligible & id_sel);
  assign ack_hit  = (state_q == PRESENT) && irq_ack_i && (irq_ack_id_i == id_q);

  // Clear first, then OR in new edges, so a same-cycle edge wins the collision.
  assign epend_d = ((epend_q & ~(ack_hit ? id_sel : '0)) | (src_i & ~src_q)) & EdgeSrc;

  // Any acknowledge that is not a hit is illegal and has no other effect.
  assign ack_err_d = irq_ack_i & ~ack_hit;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = PRESENT;
          id_d    = win_id;
        end
      end
      PRESENT: begin
        // The acknowledge takes precedence over a same-cycle withdrawal.
        if (ack_hit)        state_d = GAP;
        else if (!elig_cur) state_d = IDLE;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      epend_q   <= '0;
      id_q      <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_i;
      epend_q   <= epend_d;
      id_q      <= id_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign irq_o     = (state_q == PRESENT);
  assign irq_id_o  = id_q;
  assign pending_o = pending;
  assign ack_err_o = ack_err_q;

endmodule

// File: tb/tb_flexbex_irq_source_arbiter.sv
module tb_flexbex_irq_source_arbiter;
  localparam int          N  = 32;
  localparam logic [31:0] EM = 32'hFFEF_FFFB; // sources 2 and 20 are level

  logic          clk, rst;
  logic [N-1:0]  src_i, src_en_i, pending_o;
  logic          irq_o, irq_ack_i, ack_err_o;
  logic [4:0]    irq_id_o, irq_ack_id_i;

  flexbex_irq_source_arbiter #(.NUM_SRC(N), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .src_i(src_i), .src_en_i(src_en_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i),
    .irq_ack_id_i(irq_ack_id_i), .pending_o(pending_o), .ack_err_o(ack_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: sticky flags per edge source, and the previous line
  // value for level sources. "busy" means a request is on the wire, and
  // "quiet" counts the forced low cycles that follow an accepted acknowledge.
  logic [31:0] m_flag, m_prev;
  bit          m_busy, m_err;
  int          m_id, m_quiet;

  function automatic logic [31:0] m_pending();
    return (m_flag & EM) | (m_prev & ~EM);
  endfunction

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flag = '0; m_prev = '0; m_busy = 0; m_err = 0; m_id = 0; m_quiet = 0;
    end else begin
      logic [31:0] elig, rise;
      bit          accepted;
      int          w;
      elig     = m_pending() & src_en_i;
      rise     = src_i & ~m_prev;
      accepted = m_busy && irq_ack_i && (int'(irq_ack_id_i) == m_id);
      m_err    = irq_ack_i && !accepted;
      if (accepted) m_flag[m_id] = 1'b0;
      m_flag = (m_flag | rise) & EM;
      if (m_busy) begin
        if (accepted) begin m_busy = 0; m_quiet = 1; end
        else if (!elig[m_id]) m_busy = 0;
      end else if (m_quiet > 0) begin
        m_quiet--;
      end else begin
        w = lowest(elig);
        if (w >= 0) begin m_busy = 1; m_id = w; end
      end
      m_prev = src_i;
    end
  end

  task automatic mcmp();
    chk("model irq_o", {31'd0, irq_o}, {31'd0, m_busy});
    chk("model irq_id_o", {27'd0, irq_id_o}, 32'(m_id));
    chk("model pending_o", pending_o, m_pending());
    chk("model ack_err_o", {31'd0, ack_err_o}, {31'd0, m_err});
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mcmp();
  endtask

  typedef struct {
    logic [31:0] src;
    logic        ack;
    logic [4:0]  aid;
    logic        eirq;
    logic [4:0]  eid;
    logic [31:0] epend;
    logic        eerr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int k;
    logic [31:0] r;
    tbl[0]  = '{32'h88, 1'b0, 5'd0, 1'b0, 5'd0, 32'h00, 1'b0};
    tbl[1]  = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd0, 32'h88, 1'b0};
    tbl[2]  = '{32'h00, 1'b0, 5'd0, 1'b1, 5'd3, 32'h88, 1'b0};
    tbl[3]  = '{32'h00, 1'b1, 5'd3, 1'b1, 5'd3, 32'h88, 1'b0};
    tbl[4]  = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd3, 32'h80, 1'b0};
    tbl[5]  = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd3, 32'h80, 1'b0};
    tbl[6]  = '{32'h00, 1'b0, 5'd0, 1'b1, 5'd7, 32'h80, 1'b0};
    tbl[7]  = '{32'h00, 1'b1, 5'd6, 1'b1, 5'd7, 32'h80, 1'b0};
    tbl[8]  = '{32'h00, 1'b0, 5'd0, 1'b1, 5'd7, 32'h80, 1'b1};
    tbl[9]  = '{32'h00, 1'b1, 5'd7, 1'b1, 5'd7, 32'h80, 1'b0};
    tbl[10] = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd7, 32'h00, 1'b0};
    tbl[11] = '{32'h00, 1'b1, 5'd0, 1'b0, 5'd7, 32'h00, 1'b0};
    tbl[12] = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd7, 32'h00, 1'b1};
    tbl[13] = '{32'h00, 1'b0, 5'd0, 1'b0, 5'd7, 32'h00, 1'b0};

    // Reset with every line high, then release.
    rst = 1'b1; src_i = '1; src_en_i = '1; irq_ack_i = 1'b0; irq_ack_id_i = '0;
    repeat (3) step();
    chk("rst irq_o", {31'd0, irq_o}, 32'd0);
    chk("rst pending_o", pending_o, 32'd0);
    rst = 1'b0;
    step();
    chk("rel+1 irq_o", {31'd0, irq_o}, 32'd0);
    step();
    chk("rel+2 irq_o", {31'd0, irq_o}, 32'd1);
    chk("rel+2 irq_id_o", {27'd0, irq_id_o}, 32'd0);
    // Asynchronous reset in the middle of a request.
    rst = 1'b1;
    #1;
    chk("async irq_o", {31'd0, irq_o}, 32'd0);
    chk("async pending_o", pending_o, 32'd0);
    chk("async irq_id_o", {27'd0, irq_id_o}, 32'd0);
    src_i = '0;
    step(); step();
    rst = 1'b0;
    step(); step();

    // Table: priority, acknowledge, wrong id, and an acknowledge while idle.
    for (int i = 0; i < 14; i++) begin
      src_i = tbl[i].src; irq_ack_i = tbl[i].ack; irq_ack_id_i = tbl[i].aid;
      chk($sformatf("tbl%0d irq_o", i), {31'd0, irq_o}, {31'd0, tbl[i].eirq});
      chk($sformatf("tbl%0d irq_id_o", i), {27'd0, irq_id_o}, {27'd0, tbl[i].eid});
      chk($sformatf("tbl%0d pending_o", i), pending_o, tbl[i].epend);
      chk($sformatf("tbl%0d ack_err_o", i), {31'd0, ack_err_o}, {31'd0, tbl[i].eerr});
      step();
    end
    irq_ack_i = 1'b0; src_i = '0;

    // A new edge on source 5 collides with the acknowledge of id 5.
    src_i = 32'h20; step();
    src_i = 32'h0;  step();
    chk("col present", {27'd0, irq_id_o, irq_o}, {27'd5, 1'b1});
    step();
    src_i = 32'h20; irq_ack_i = 1'b1; irq_ack_id_i = 5'd5; step();
    src_i = 32'h0;  irq_ack_i = 1'b0;
    chk("col gap irq_o", {31'd0, irq_o}, 32'd0);
    chk("col pend5", {31'd0, pending_o[5]}, 32'd1);
    step();
    chk("col idle irq_o", {31'd0, irq_o}, 32'd0);
    step();
    chk("col re-present", {27'd0, irq_id_o, irq_o}, {27'd5, 1'b1});
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd5; step();
    irq_ack_i = 1'b0; step(); step();

    // Level source 2 withdrawn by dropping the line, then by masking it.
    for (int v = 0; v < 2; v++) begin
      src_i = 32'h4; k = 0;
      while (!irq_o && k < 8) begin step(); k++; end
      chk("lvl present", {27'd0, irq_id_o, irq_o}, {27'd2, 1'b1});
      if (v == 0) src_i = 32'h0; else src_en_i[2] = 1'b0;
      step();
      step();
      chk($sformatf("lvl%0d withdrawn irq_o", v), {31'd0, irq_o}, 32'd0);
      chk($sformatf("lvl%0d ack_err_o", v), {31'd0, ack_err_o}, 32'd0);
      src_i = 32'h0; src_en_i = '1; step(); step();
    end

    // Wrong acknowledge id while presenting id 4.
    src_i = 32'h10; step();
    src_i = 32'h0;  step();
    chk("bad present", {27'd0, irq_id_o, irq_o}, {27'd4, 1'b1});
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd6; step();
    irq_ack_i = 1'b0;
    chk("bad ack_err_o", {31'd0, ack_err_o}, 32'd1);
    chk("bad holds", {27'd0, irq_id_o, irq_o}, {27'd4, 1'b1});
    chk("bad pend4", {31'd0, pending_o[4]}, 32'd1);
    step();
    chk("bad err pulse", {31'd0, ack_err_o}, 32'd0);
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd4; step();
    irq_ack_i = 1'b0; step(); step();

    // id 9 stays presented while the higher-priority source 1 arrives.
    src_i = 32'h200; step();
    src_i = 32'h0;   step();
    chk("stab present9", {27'd0, irq_id_o, irq_o}, {27'd9, 1'b1});
    src_i = 32'h2; step();
    src_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stab hold%0d", i), {27'd0, irq_id_o, irq_o}, {27'd9, 1'b1});
      step();
    end
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd9; step();
    irq_ack_i = 1'b0;
    chk("stab gap", {31'd0, irq_o}, 32'd0);
    step(); step();
    chk("stab present1", {27'd0, irq_id_o, irq_o}, {27'd1, 1'b1});
    irq_ack_i = 1'b1; irq_ack_id_i = 5'd1; step();
    irq_ack_i = 1'b0; step(); step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      src_i    = src_i ^ ($urandom & $urandom & $urandom & $urandom);
      src_en_i = ~($urandom & $urandom & $urandom & $urandom & $urandom);
      r = $urandom_range(0, 99);
      irq_ack_i = 1'b0; irq_ack_id_i = 5'($urandom_range(0, 31));
      if (m_busy && r < 30) begin irq_ack_i = 1'b1; irq_ack_id_i = 5'(m_id); end
      else if (r >= 95) irq_ack_i = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
